uart_rx: RTL and testbench

Interrupt-capable UART receiver that fills the `rxd` input, which is still unused in the SoC. It sits on the CPU memory bus beside the transmit-only `uart` peripheral at base 0x1600_0000 (`addr[31:24] == 8'h16`). It deserialises 8N1 frames into a byte FIFO and exposes data and status registers. It drives its own `ready`, in the same way `spi_ready` is ORed into the CPU ready.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - register map, status bit positions and receiver state type
package uart_rx_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_NE      = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through read data
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + 1'b1;
      end
      if (do_pop) begin
        rp <= rp + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with byte FIFO, status flags and bus interface
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ = 20000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic        valid,
  output logic        ready,
  input  logic        rxd,
  output logic        irq
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            push;
  logic            ferr_set;

  logic            acc;
  logic            rd_data;
  logic            wr_status;
  logic            ovr_set;
  logic            overrun;
  logic            frame_err;
  logic [7:0]      rdata;
  logic            full;
  logic            empty;
  logic [AW:0]     fifo_count;
  logic [8:0]      count9;
  logic [31:0]     status;
  logic            unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        // Edge-triggered so a held-low line (break) cannot restart a frame.
        if (!rx_s && rx_prev) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = DIV_M1;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = DIV_M1;
          idx_d = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          push     = rx_s;
          ferr_set = ~rx_s;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rd_data),
    .wdata (sh_q),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign acc       = valid & ~ready;
  assign rd_data   = acc & ~wr & (addr[2] == REG_DATA);
  assign wr_status = acc & wr & (addr[2] == REG_STATUS);
  assign ovr_set   = push & full & ~rd_data;
  assign irq       = ~empty;

  always_comb begin
    count9             = '0;
    count9[AW:0]       = fifo_count;
    status             = '0;
    status[ST_NE]      = ~empty;
    status[ST_FULL]    = full;
    status[ST_OVR]     = overrun;
    status[ST_FERR]    = frame_err;
    status[ST_CNT_LSB +: 9] = count9;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready     <= 1'b0;
      dout      <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready <= acc;
      if (acc) begin
        if (wr) begin
          dout <= '0;
        end else if (addr[2] == REG_STATUS) begin
          dout <= status;
        end else begin
          dout <= empty ? 32'h0000_0100 : {24'd0, rdata};
        end
      end
      // A set in the same cycle as a clear takes priority.
      overrun   <= ovr_set  | (overrun   & ~(wr_status & din[ST_OVR]));
      frame_err <= ferr_set | (frame_err & ~(wr_status & din[ST_FERR]));
    end
  end

  assign unused = ^{addr[31:3], addr[1:0], din[31:4], din[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a queue model
module tb_uart_rx;

  localparam int CLK_HZ = 20000000;
  localparam int BAUD   = 115200;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int LAT    = 2 + HALF + 9 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        wr;
  logic        valid;
  logic        ready;
  logic        rxd;
  logic        irq;

  int          total = 0;
  int          bad   = 0;
  byte unsigned q[$];
  bit          m_ovr;
  bit          m_ferr;
  bit          abort;
  int          n;
  logic [31:0] r;
  logic [31:0] d;
  byte unsigned b;
  byte unsigned h;
  bit          ok;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .wr    (wr),
    .valid (valid),
    .ready (ready),
    .rxd   (rxd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (q.size() != 0);
    s[1]    = (q.size() == DEPTH);
    s[2]    = m_ovr;
    s[3]    = m_ferr;
    s[16:8] = 9'(q.size());
    return s;
  endfunction

  task automatic model_rx(input byte unsigned v, input bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(v);
  endtask

  task automatic bus(input logic w, input logic a2, input logic [31:0] wd, output logic [31:0] rd);
    int k;
    k     = 0;
    addr  = {8'h16, 21'd0, a2, 2'b00};
    wr    = w;
    din   = wd;
    valid = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 8);
    check("ack", ready, 1'b1);
    rd    = dout;
    valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rv;
    logic [31:0] ev;
    bus(1'b0, 1'b0, 32'h0, rv);
    ev = (q.size() != 0) ? {24'd0, q.pop_front()} : 32'h100;
    check(tag, rv, ev);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] rv;
    bus(1'b0, 1'b1, 32'h0, rv);
    check(tag, rv, exp_status());
  endtask

  task automatic send(input byte unsigned v, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, v, 1'b0};
    for (int c = 0; c < 10 * DIV && !abort; c++) begin
      rxd = fr[c / DIV];
      @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rxd = 1'b1; valid = 1'b0; wr = 1'b0; addr = '0; din = '0; abort = 1'b0;
    m_ovr = 1'b0; m_ferr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    check("rst_irq", irq, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_dout", dout, 32'h0);
    read_status("rst_status");

    // single byte with irq latency measured from the start edge
    n = 0;
    fork
      send(8'h55, 1'b1);
      begin
        while (!irq && n < 3000) begin
          @(negedge clk);
          n++;
        end
      end
    join
    check("irq_lat", n, LAT + 1);
    model_rx(8'h55, 1'b1);
    read_data("single_data");
    read_status("single_status");

    // glitch rejection
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    read_status("glitch_status");
    check("glitch_irq", irq, 1'b0);

    // frame error and its W1C clear
    send(8'hA3, 1'b0);
    model_rx(8'hA3, 1'b0);
    read_status("ferr_status");
    bus(1'b1, 1'b1, 32'h8, r);
    m_ferr = 1'b0;
    read_status("ferr_clear");

    // DATA write is acknowledged and has no effect
    bus(1'b1, 1'b0, 32'hFF, r);
    read_status("dwr_status");

    // overrun
    for (int i = 0; i < 17; i++) begin
      send(8'(i), 1'b1);
      model_rx(8'(i), 1'b1);
    end
    read_status("ovr_status");
    check("ovr_irq", irq, 1'b1);
    bus(1'b1, 1'b1, 32'h4, r);
    m_ovr = 1'b0;
    read_status("ovr_clear");

    // pop lands on the same edge as the stop-bit push into a full FIFO
    fork
      send(8'hC5, 1'b1);
      begin
        repeat (LAT) @(negedge clk);
        bus(1'b0, 1'b0, 32'h0, r);
      end
    join
    h = q.pop_front();
    q.push_back(8'hC5);
    check("pof_data", r, {24'd0, h});
    read_status("pof_status");

    for (int i = 0; i < DEPTH; i++) read_data("drain_data");
    read_data("empty_data");
    read_status("drain_status");
    check("drain_irq", irq, 1'b0);

    // reset during DATA bit 4, then a clean frame
    b = 8'($urandom);
    fork
      send(b, 1'b1);
      begin
        repeat (5 * DIV + DIV / 2) @(negedge clk);
        abort = 1'b1;
        do_reset();
      end
    join
    repeat (300) @(negedge clk);
    abort = 1'b0;
    read_status("midrst_status");
    send(8'h7E, 1'b1);
    model_rx(8'h7E, 1'b1);
    read_data("midrst_data");
    read_status("midrst_after");

    // randomized frames, reads and W1C writes
    for (int i = 0; i < 10; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send(b, ok);
      model_rx(b, ok);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      check("rnd_irq", irq, (q.size() != 0));
      if ($urandom_range(0, 1) == 1) read_data("rnd_data");
      if ($urandom_range(0, 1) == 1) read_status("rnd_status");
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        bus(1'b1, 1'b1, d, r);
        if (d[2]) m_ovr = 1'b0;
        if (d[3]) m_ferr = 1'b0;
      end
    end
    read_status("rnd_final_status");
    while (q.size() != 0) read_data("rnd_drain");
    read_data("rnd_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
